// File: rtl/unidad_busqueda.sv
// Instruction-fetch unit: owns the PC, issues one word read at a time and
// holds a single fetched instruction for decode, dropping wrong-path fetches.
//
// state     | meaning
// ----------+-------------------------------------------
// INICIO    | no request (one cycle after reset)
// PEDIR     | request outstanding to instruction memory
// LLENO     | instruction held for decode
// DESCARTAR | in-flight request will be dropped
module unidad_busqueda #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [31:0] PC,
  input  logic [31:0] SAL,
  input  logic        SALTO,
  input  logic [31:0] DIR_SALTO,
  input  logic        DETENER,
  output logic        MEM_REQ,
  output logic [31:0] MEM_DIR,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_DATO,
  output logic [31:0] INSTR,
  output logic [31:0] PC_INSTR,
  output logic        INSTR_VALIDA
);

  typedef enum logic [1:0] {INICIO, PEDIR, LLENO, DESCARTAR} estado_t;

  estado_t     estado, estado_sig;
  logic [31:0] pc_sig, instr_sig, pc_instr_sig;
  logic [31:0] pendiente, pendiente_sig;
  logic [31:0] destino;
  logic        unused_dir_bajos;

  assign destino          = {DIR_SALTO[31:2], 2'b00};
  assign unused_dir_bajos = ^DIR_SALTO[1:0];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      estado    <= INICIO;
      PC        <= RESET_VECTOR;
      INSTR     <= 32'h0;
      PC_INSTR  <= 32'h0;
      pendiente <= 32'h0;
    end else begin
      estado    <= estado_sig;
      PC        <= pc_sig;
      INSTR     <= instr_sig;
      PC_INSTR  <= pc_instr_sig;
      pendiente <= pendiente_sig;
    end
  end

  always_comb begin
    estado_sig    = estado;
    pc_sig        = PC;
    instr_sig     = INSTR;
    pc_instr_sig  = PC_INSTR;
    pendiente_sig = pendiente;
    case (estado)
      INICIO: estado_sig = PEDIR;
      PEDIR: begin
        if (MEM_ACK && !SALTO) begin
          instr_sig    = MEM_DATO;
          pc_instr_sig = PC;
          pc_sig       = SAL;
          estado_sig   = LLENO;
        end else if (MEM_ACK && SALTO) begin
          pc_sig = destino;
        end else if (SALTO) begin
          // PC (and so MEM_DIR) must stay put until the old request completes
          pendiente_sig = destino;
          estado_sig    = DESCARTAR;
        end
      end
      LLENO: begin
        if (SALTO) begin
          pc_sig     = destino;
          estado_sig = PEDIR;
        end else if (!DETENER) begin
          estado_sig = PEDIR;
        end
      end
      DESCARTAR: begin
        if (SALTO) pendiente_sig = destino;
        if (MEM_ACK) begin
          pc_sig     = SALTO ? destino : pendiente;
          estado_sig = PEDIR;
        end
      end
      default: estado_sig = INICIO;
    endcase
  end

  assign MEM_REQ      = (estado == PEDIR) || (estado == DESCARTAR);
  assign INSTR_VALIDA = (estado == LLENO);
  assign MEM_DIR      = PC;

endmodule

// File: tb/tb_unidad_busqueda.sv
// Bench for unidad_busqueda: two instances (reset vector 0 and 0xFFFF_FFFC)
// share stimulus and are checked every cycle against a behavioural model.
module tb_unidad_busqueda;

  logic        CLK = 1'b0;
  logic        RESET, SALTO, DETENER, MEM_ACK;
  logic [31:0] DIR_SALTO, MEM_DATO;

  logic [31:0] pc_a, sal_a, dir_a, instr_a, pci_a;
  logic        req_a, val_a;
  logic [31:0] pc_b, sal_b, dir_b, instr_b, pci_b;
  logic        req_b, val_b;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  assign sal_a = pc_a + 32'd4;
  assign sal_b = pc_b + 32'd4;

  unidad_busqueda #(.RESET_VECTOR(32'h0000_0000)) dut_a (
    .CLK(CLK), .RESET(RESET), .PC(pc_a), .SAL(sal_a), .SALTO(SALTO),
    .DIR_SALTO(DIR_SALTO), .DETENER(DETENER), .MEM_REQ(req_a), .MEM_DIR(dir_a),
    .MEM_ACK(MEM_ACK), .MEM_DATO(MEM_DATO), .INSTR(instr_a), .PC_INSTR(pci_a),
    .INSTR_VALIDA(val_a));

  unidad_busqueda #(.RESET_VECTOR(32'hFFFF_FFFC)) dut_b (
    .CLK(CLK), .RESET(RESET), .PC(pc_b), .SAL(sal_b), .SALTO(SALTO),
    .DIR_SALTO(DIR_SALTO), .DETENER(DETENER), .MEM_REQ(req_b), .MEM_DIR(dir_b),
    .MEM_ACK(MEM_ACK), .MEM_DATO(MEM_DATO), .INSTR(instr_b), .PC_INSTR(pci_b),
    .INSTR_VALIDA(val_b));

  // Model: a fetch unit described by what it is doing, not by an encoding.
  logic [31:0] rv [2];
  bit          m_start [2];  // first cycle after reset, nothing requested yet
  bit          m_busy  [2];  // a memory read is outstanding
  bit          m_drop  [2];  // the outstanding read belongs to the wrong path
  bit          m_full  [2];  // an instruction is offered to decode
  logic [31:0] m_pc [2], m_tgt [2], m_instr [2], m_pci [2];
  int          presented_8;

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  task automatic model_edge();
    for (int u = 0; u < 2; u++) begin
      if (RESET) begin
        m_start[u] = 1; m_busy[u] = 0; m_drop[u] = 0; m_full[u] = 0;
        m_pc[u] = rv[u]; m_tgt[u] = 0; m_instr[u] = 0; m_pci[u] = 0;
      end else if (m_start[u]) begin
        m_start[u] = 0; m_busy[u] = 1;
      end else if (m_busy[u] && m_drop[u]) begin
        if (SALTO) m_tgt[u] = align(DIR_SALTO);
        if (MEM_ACK) begin
          m_drop[u] = 0;
          m_pc[u]   = m_tgt[u];
        end
      end else if (m_busy[u]) begin
        if (MEM_ACK && SALTO) m_pc[u] = align(DIR_SALTO);
        else if (MEM_ACK) begin
          m_busy[u] = 0; m_full[u] = 1;
          m_instr[u] = MEM_DATO; m_pci[u] = m_pc[u]; m_pc[u] = m_pc[u] + 32'd4;
        end else if (SALTO) begin
          m_drop[u] = 1; m_tgt[u] = align(DIR_SALTO);
        end
      end else if (m_full[u]) begin
        if (SALTO) begin
          m_full[u] = 0; m_busy[u] = 1; m_pc[u] = align(DIR_SALTO);
        end else if (!DETENER) begin
          m_full[u] = 0; m_busy[u] = 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("a.mem_req", {31'b0, req_a}, {31'b0, m_busy[0]});
    chk("a.valida",  {31'b0, val_a}, {31'b0, m_full[0]});
    chk("a.pc",      pc_a,  m_pc[0]);
    chk("a.mem_dir", dir_a, m_pc[0]);
    chk("b.mem_req", {31'b0, req_b}, {31'b0, m_busy[1]});
    chk("b.valida",  {31'b0, val_b}, {31'b0, m_full[1]});
    chk("b.pc",      pc_b,  m_pc[1]);
    chk("b.mem_dir", dir_b, m_pc[1]);
    if (m_full[0] || m_start[0]) begin
      chk("a.instr",    instr_a, m_instr[0]);
      chk("a.pc_instr", pci_a,   m_pci[0]);
    end
    if (m_full[1] || m_start[1]) begin
      chk("b.instr",    instr_b, m_instr[1]);
      chk("b.pc_instr", pci_b,   m_pci[1]);
    end
    if (val_a === 1'b1 && pci_a === 32'h8) presented_8++;
  endtask

  task automatic step(input bit rst, input bit sal, input logic [31:0] dir,
                      input bit ack, input bit det);
    RESET = rst; SALTO = sal; DIR_SALTO = dir; MEM_ACK = ack; DETENER = det;
    MEM_DATO = $urandom;
    @(negedge CLK);
    check_outputs();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  initial begin
    rv[0] = 32'h0000_0000;
    rv[1] = 32'hFFFF_FFFC;
    presented_8 = 0;
    RESET = 1; SALTO = 0; DIR_SALTO = 0; MEM_ACK = 1; DETENER = 0; MEM_DATO = 0;
    @(posedge CLK);
    model_edge();
    #1;
    step(1, 0, 0, 1, 0);
    // zero-wait fetch of 0x0 and 0x4; b wraps 0xFFFF_FFFC -> 0x0
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
    chk("a.held_pc4", pci_a, 32'h4);
    chk("b.wrap_pc", pc_b, 32'h0000_0004);
    // stall three cycles while 0x4 is held
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("a.fetch_after_stall", pci_a, 32'h8);
    // redirect out of LLENO holding 0x8, unaligned target
    step(0, 1, 32'h103, 1, 0);
    chk("a.redirect_dir", dir_a, 32'h100);
    presented_8 = 0;
    step(0, 0, 0, 1, 0);
    step(0, 1, 32'hC, 1, 0);
    // in PEDIR at 0xC: redirect, ack delayed three cycles
    step(0, 1, 32'h200, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("a.dir_held", dir_a, 32'hC);
    step(0, 0, 0, 1, 0);
    chk("a.after_drop", dir_a, 32'h200);
    // two redirects while discarding
    step(0, 1, 32'h200, 0, 0);
    step(0, 1, 32'h300, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("a.latest_target", dir_a, 32'h300);
    step(0, 1, 32'h500, 0, 0);
    step(0, 1, 32'h400, 1, 0);
    chk("a.same_cycle_target", dir_a, 32'h400);
    step(0, 0, 0, 1, 0);
    chk("a.no_stale_8", presented_8, 0);
    // reset mid-request, then a late acknowledge
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("a.late_ack_req", {31'b0, req_a}, 32'h1);
    chk("a.late_ack_val", {31'b0, val_a}, 32'h0);
    // randomized traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 79) == 0, $urandom_range(0, 5) == 0, $urandom,
           $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
